// File: rtl/mini_prog_loader_if.sv
// Byte-stream and memory-write bundle for the program loader.
// master = loader side (accepts bytes, drives the memory port); slave = source/memory side.
interface mini_prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mini_prog_loader.sv
// Framed program loader for the mini CPU memory: header, data, 8-bit additive checksum.
// Optional macro LOADER_ZERO_FILL_EN pads addresses len..15 with 8'h00 before the checksum byte.
module mini_prog_loader #(
  parameter int         MEM_DEPTH = 16,
  parameter logic [3:0] MAGIC     = 4'hA,
  parameter int         TIMEOUT   = 255
) (
  input  logic                   i_step,
  input  logic                   i_reset,
  input  logic                   i_start,
  mini_prog_loader_if.master     bus,
  output logic                   o_cpu_hold,
  output logic                   o_done,
  output logic                   o_error
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO       = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_LEN  = CNT_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef LOADER_ZERO_FILL_EN
    S_FILL,
`endif
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_addr, r_len;
  logic [7:0]       r_csum;
  logic [TMR_W-1:0] r_timer;
  logic             r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]       r_mem_wdata;

  logic             w_xfer, w_active, w_start_ok, w_tmo, w_last;
  logic [TMR_W-1:0] w_tmr_inc;

  assign w_xfer     = bus.in_valid & bus.in_ready;
  assign w_active   = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_tmr_inc  = r_timer + 1'b1;
  // Timeout fires on the edge closing the TIMEOUT-th consecutive idle cycle.
  assign w_tmo      = (TIMEOUT != 0) && w_active && !w_xfer && (w_tmr_inc == TMO);
  assign w_last     = ((r_addr + 1'b1) == r_len);

  always_ff @(posedge i_step or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_HDR;
      S_HDR: begin
        if (w_xfer)     w_next = (bus.in_data[7:4] != MAGIC) ? S_ERR : S_DATA;
        else if (w_tmo) w_next = S_ERR;
      end
      S_DATA: begin
        if (w_xfer && w_last) begin
`ifdef LOADER_ZERO_FILL_EN
          w_next = (r_len != FULL_LEN) ? S_FILL : S_CSUM;
`else
          w_next = S_CSUM;
`endif
        end else if (w_tmo) begin
          w_next = S_ERR;
        end
      end
`ifdef LOADER_ZERO_FILL_EN
      S_FILL: if (r_addr == LAST_ADDR) w_next = S_CSUM;
`endif
      S_CSUM: begin
        if (w_xfer)     w_next = (bus.in_data == r_csum) ? S_DONE : S_ERR;
        else if (w_tmo) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    o_cpu_hold   = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      S_HDR, S_DATA, S_CSUM: begin
        bus.in_ready = 1'b1;
        o_cpu_hold   = 1'b1;
      end
`ifdef LOADER_ZERO_FILL_EN
      S_FILL: o_cpu_hold = 1'b1;
`endif
      S_DONE: o_done = 1'b1;
      S_ERR: begin
        o_error    = 1'b1;
        o_cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_step or posedge i_reset) begin
    if (i_reset) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_csum      <= '0;
      r_timer     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start_ok) begin
        r_addr  <= '0;
        r_csum  <= '0;
        r_timer <= '0;
      end
      if (w_active) r_timer <= w_xfer ? '0 : w_tmr_inc;
      if (w_xfer && (r_state == S_HDR)) r_len <= CNT_W'(bus.in_data[3:0]) + 1'b1;
      if (w_xfer && (r_state == S_DATA)) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_addr[ADDR_W-1:0];
        r_mem_wdata <= bus.in_data;
        r_csum      <= r_csum + bus.in_data;
        r_addr      <= r_addr + 1'b1;
      end
`ifdef LOADER_ZERO_FILL_EN
      if (r_state == S_FILL) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_addr[ADDR_W-1:0];
        r_mem_wdata <= 8'h00;
        r_addr      <= r_addr + 1'b1;
      end
`endif
    end
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mini_prog_loader.sv
// Scoreboard bench for mini_prog_loader: expected memory writes queued on byte acceptance.
module tb_mini_prog_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic hold, done, error;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;
  wr_t sb_q[$];

  mini_prog_loader_if bus ();

  mini_prog_loader #(.TIMEOUT(4)) u_dut (
    .i_step    (clk),
    .i_reset   (rst),
    .i_start   (start),
    .bus       (bus),
    .o_cpu_hold(hold),
    .o_done    (done),
    .o_error   (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        if (sb_q.size() == 0) begin
          chk("unexp_we", bus.mem_we, 1'b0);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          chk("wr_addr", bus.mem_addr, e.a);
          chk("wr_data", bus.mem_wdata, e.d);
          chk("wr_cyc", cyc, e.c);
        end
      end
      if (done && error) chk("done_err_excl", error, 1'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle number in which a resulting write strobe must be visible.
  task automatic send_byte(input logic [7:0] b, output int wcyc);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    wcyc = -1;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk); #1;
      if (ok) wcyc = cyc;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("rdy_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic load(input logic [7:0] hdr, input logic [7:0] dat[$],
                      input logic [7:0] cs, input int gap);
    int  w;
    wr_t e;
    send_byte(hdr, w);
    foreach (dat[i]) begin
      idle(gap);
      send_byte(dat[i], w);
      e.a = 4'(i); e.d = dat[i]; e.c = w;
      sb_q.push_back(e);
    end
`ifdef LOADER_ZERO_FILL_EN
    if (dat.size() < 16) begin
      for (int a = dat.size(); a < 16; a++) begin
        e.a = 4'(a); e.d = 8'h00; e.c = w + a - dat.size() + 1;
        sb_q.push_back(e);
      end
      @(negedge clk);
      chk("fill_rdy", bus.in_ready, 1'b0);
    end
`endif
    idle(gap);
    send_byte(cs, w);
  endtask

  task automatic chk_end(input string tag, input logic e_done, input logic e_err, input logic e_hold);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_err"}, error, e_err);
    chk({tag, "_hold"}, hold, e_hold);
    chk({tag, "_rdy"}, bus.in_ready, 1'b0);
    chk({tag, "_sb"}, sb_q.size(), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int w;
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    #3;
    chk("rst_rdy", bus.in_ready, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 4'h0);
    chk("rst_wdata", bus.mem_wdata, 8'h00);
    chk("rst_hold", hold, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    #9 rst = 1'b0;
    idle(2);

    // Basic frame, len 4
    do_start();
    chk("start_hold", hold, 1'b1);
    chk("start_rdy", bus.in_ready, 1'b1);
    q = {8'h41, 8'h62, 8'h80, 8'hC2};
    load(8'hA3, q, sum8(q), 0);
    chk_end("basic", 1'b1, 1'b0, 1'b0);

    // Bad magic, then a clean reload clears error
    do_start();
    chk("restart_done", done, 1'b0);
    send_byte(8'h53, w);
    chk_end("badhdr", 1'b0, 1'b1, 1'b1);
    idle(2);
    do_start();
    chk("restart_err", error, 1'b0);
    q = {8'h41, 8'h62};
    load(8'hA1, q, 8'hA3, 0);
    chk_end("reload", 1'b1, 1'b0, 1'b0);

    // Bad checksum, data writes still issued
    do_start();
    q = {8'h10, 8'h20};
    load(8'hA1, q, 8'h31, 0);
    chk_end("badcs", 1'b0, 1'b1, 1'b1);

    // Full 16-word frame, back-to-back then with in_valid toggling
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'h01);
    do_start();
    load(8'hAF, q, 8'h10, 0);
    chk_end("full", 1'b1, 1'b0, 1'b0);
    do_start();
    load(8'hAF, q, 8'h10, 1);
    chk_end("toggle", 1'b1, 1'b0, 1'b0);

    // Timeout after 4 idle cycles in DATA
    do_start();
    send_byte(8'hA0, w);
    idle(3);
    chk("tmo_early", error, 1'b0);
    idle(1);
    chk("tmo_err", error, 1'b1);
    chk("tmo_hold", hold, 1'b1);

    // Async reset mid-DATA while a write strobe is up
    do_start();
    send_byte(8'hA5, w);
    send_byte(8'h11, w);
    chk("we_pre_rst", bus.mem_we, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_we", bus.mem_we, 1'b0);
    chk("arst_rdy", bus.in_ready, 1'b0);
    chk("arst_hold", hold, 1'b0);
    chk("arst_addr", bus.mem_addr, 4'h0);
    chk("arst_err", error, 1'b0);
    sb_q.delete();
    #4 rst = 1'b0;
    idle(3);
    chk("post_rst_rdy", bus.in_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
